// File: rtl/pwm_capture.sv
// Purpose: measures period and high time of an asynchronous PWM input in clk cycles.
// Latency: meas_valid on the (SYNC_STAGES+1)-th clk edge after pwm_in rises.
// Backpressure: none; each result is a one-cycle strobe that the consumer must take as it comes.
module pwm_capture #(
   parameter int CNT_WIDTH      = 32,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 enable,
   input  logic                 pwm_in,
   output logic [CNT_WIDTH-1:0] period_cycles,
   output logic [CNT_WIDTH-1:0] high_cycles,
   output logic                 meas_valid,
   output logic                 signal_lost,
   output logic                 pwm_level
);

   typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

   localparam logic [CNT_WIDTH-1:0] TIMEOUT = CNT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [CNT_WIDTH-1:0] ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   level;
   logic                   rise;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   run_q, run_d;
   logic [CNT_WIDTH-1:0]   high_q, high_d;
   logic [CNT_WIDTH-1:0]   per_q, per_d;
   logic [CNT_WIDTH-1:0]   hi_q, hi_d;
   logic                   vld_q, vld_d;
   logic                   lost_q, lost_d;

   // Counters stick at all-ones rather than wrapping to a small bogus value.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + ONE;
   endfunction

   assign level = sync_q[SYNC_STAGES-1];
   assign rise  = level & ~prev_q;

   // Synchronizer and edge-detect history run even while disabled, so enabling
   // with the input already high cannot look like a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
         prev_q <= level;
      end
   end

   // State, counters and published results.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         run_q   <= '0;
         high_q  <= '0;
         per_q   <= '0;
         hi_q    <= '0;
         vld_q   <= 1'b0;
         lost_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         high_q  <= high_d;
         per_q   <= per_d;
         hi_q    <= hi_d;
         vld_q   <= vld_d;
         lost_q  <= lost_d;
      end
   end

   // Next-state logic: disable clears everything; a rise always beats the timeout.
   always_comb begin
      state_d = state_q;
      run_d   = run_q;
      high_d  = high_q;
      per_d   = per_q;
      hi_d    = hi_q;
      vld_d   = 1'b0;
      lost_d  = lost_q;
      if (!enable) begin
         state_d = IDLE;
         run_d   = '0;
         high_d  = '0;
         per_d   = '0;
         hi_d    = '0;
         lost_d  = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = ARM;
            end
            ARM: begin
               // First edge only starts the count; there is no full period yet.
               if (rise) begin
                  run_d   = ONE;
                  high_d  = ONE;
                  state_d = MEASURE;
               end else if (run_q == TIMEOUT) begin
                  lost_d = 1'b1;
                  run_d  = '0;
               end else begin
                  run_d = sat_inc(run_q);
               end
            end
            MEASURE: begin
               if (rise) begin
                  per_d  = run_q;
                  hi_d   = high_q;
                  vld_d  = 1'b1;
                  lost_d = 1'b0;
                  run_d  = ONE;
                  high_d = ONE;
               end else if (run_q == TIMEOUT) begin
                  // Results hold their last values; re-arm for a fresh first edge.
                  lost_d  = 1'b1;
                  run_d   = '0;
                  high_d  = '0;
                  state_d = ARM;
               end else begin
                  run_d = sat_inc(run_q);
                  if (level) begin
                     high_d = sat_inc(high_q);
                  end
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   assign period_cycles = per_q;
   assign high_cycles   = hi_q;
   assign meas_valid    = vld_q;
   assign signal_lost   = lost_q;
   assign pwm_level     = level;

endmodule

// File: tb/tb_pwm_capture.sv
// Purpose: directed testbench for pwm_capture with TIMEOUT_CYCLES = 100.
// Latency: stimulus and sampling both happen on the falling clk edge.
// Backpressure: none; the DUT has no ready input.
module tb_pwm_capture;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        pwm_in;
   logic [31:0] period_cycles;
   logic [31:0] high_cycles;
   logic        meas_valid;
   logic        signal_lost;
   logic        pwm_level;

   int n_tests = 0;
   int n_fail  = 0;

   // Observation record, filled once per falling edge by step().
   int   cyc, vld_cnt, first_vld, last_vld, gap, badval, b2b, lost_first, lost_last;
   int   exp_p, exp_h;
   logic prev_vld;

   pwm_capture #(
      .CNT_WIDTH      (32),
      .SYNC_STAGES    (2),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .enable        (enable),
      .pwm_in        (pwm_in),
      .period_cycles (period_cycles),
      .high_cycles   (high_cycles),
      .meas_valid    (meas_valid),
      .signal_lost   (signal_lost),
      .pwm_level     (pwm_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clear_stats(input int p, input int h);
      cyc = 0; vld_cnt = 0; first_vld = -1; last_vld = -1; gap = -1;
      badval = 0; b2b = 0; lost_first = -1; lost_last = -1;
      prev_vld = 1'b0; exp_p = p; exp_h = h;
   endtask

   // One clk cycle: sample the outputs on the falling edge, then drive pwm_in.
   task automatic step(input logic v);
      @(negedge clk);
      cyc++;
      if (meas_valid) begin
         vld_cnt++;
         if (first_vld < 0) first_vld = cyc;
         if (last_vld >= 0) gap = cyc - last_vld;
         last_vld = cyc;
         if (prev_vld) b2b++;
         if (period_cycles != 32'(exp_p) || high_cycles != 32'(exp_h)) badval++;
      end
      if (signal_lost) begin
         if (lost_first < 0) lost_first = cyc;
         lost_last = cyc;
      end
      prev_vld = meas_valid;
      pwm_in   = v;
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   task automatic drive_periods(input int p, input int h, input int n);
      for (int i = 0; i < n; i++)
         for (int k = 0; k < p; k++) step(k < h);
   endtask

   task automatic restart();
      enable = 1'b0;
      hold(1'b0, 3);
      enable = 1'b1;
      hold(1'b0, 2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b0; pwm_in = 1'b0;
      @(negedge clk);
      n_tests++; if (period_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period_cycles); end
      n_tests++; if (high_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_high: got %0d want 0", high_cycles); end
      n_tests++; if ({meas_valid, signal_lost, pwm_level} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b want 000", {meas_valid, signal_lost, pwm_level}); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic_p10();
      restart();
      clear_stats(10, 3);
      drive_periods(10, 3, 5);
      hold(1'b0, 5);
      n_tests++; if (first_vld !== 14) begin n_fail++; $display("FAIL p10_first_valid_cycle: got %0d want 14", first_vld); end
      n_tests++; if (vld_cnt !== 4) begin n_fail++; $display("FAIL p10_valid_count: got %0d want 4", vld_cnt); end
      n_tests++; if (badval !== 0) begin n_fail++; $display("FAIL p10_values: %0d bad reports, want 0", badval); end
      n_tests++; if (gap !== 10) begin n_fail++; $display("FAIL p10_gap: got %0d want 10", gap); end
      n_tests++; if (period_cycles !== 32'd10 || high_cycles !== 32'd3) begin n_fail++; $display("FAIL p10_outputs: got %0d/%0d want 10/3", period_cycles, high_cycles); end
      n_tests++; if (lost_first !== -1) begin n_fail++; $display("FAIL p10_lost: signal_lost seen at %0d, want never", lost_first); end
   endtask

   task automatic test_min_p2();
      restart();
      clear_stats(2, 1);
      drive_periods(2, 1, 10);
      hold(1'b0, 5);
      n_tests++; if (vld_cnt !== 9) begin n_fail++; $display("FAIL p2_valid_count: got %0d want 9", vld_cnt); end
      n_tests++; if (first_vld !== 6) begin n_fail++; $display("FAIL p2_first_valid_cycle: got %0d want 6", first_vld); end
      n_tests++; if (gap !== 2) begin n_fail++; $display("FAIL p2_gap: got %0d want 2", gap); end
      n_tests++; if (b2b !== 0) begin n_fail++; $display("FAIL p2_back_to_back: got %0d want 0", b2b); end
      n_tests++; if (badval !== 0) begin n_fail++; $display("FAIL p2_values: %0d bad reports, want 0", badval); end
   endtask

   task automatic test_timeout_low();
      restart();
      clear_stats(10, 3);
      drive_periods(10, 3, 3);
      hold(1'b0, 120);
      n_tests++; if (vld_cnt !== 2) begin n_fail++; $display("FAIL tlow_valid_count: got %0d want 2", vld_cnt); end
      n_tests++; if (lost_first - last_vld !== 100) begin n_fail++; $display("FAIL tlow_lost_delay: got %0d want 100", lost_first - last_vld); end
      n_tests++; if (signal_lost !== 1'b1 || pwm_level !== 1'b0) begin n_fail++; $display("FAIL tlow_flags: lost=%b level=%b want 1/0", signal_lost, pwm_level); end
      n_tests++; if (period_cycles !== 32'd10 || high_cycles !== 32'd3) begin n_fail++; $display("FAIL tlow_hold: got %0d/%0d want 10/3", period_cycles, high_cycles); end
      // Resume: first rise only re-arms, second rise reports and clears the loss flag.
      clear_stats(10, 3);
      drive_periods(10, 3, 3);
      hold(1'b0, 5);
      n_tests++; if (first_vld !== 14) begin n_fail++; $display("FAIL resume_first_valid_cycle: got %0d want 14", first_vld); end
      n_tests++; if (vld_cnt !== 2) begin n_fail++; $display("FAIL resume_valid_count: got %0d want 2", vld_cnt); end
      n_tests++; if (lost_last !== 13) begin n_fail++; $display("FAIL resume_lost_clear: last lost cycle %0d want 13", lost_last); end
      n_tests++; if (badval !== 0) begin n_fail++; $display("FAIL resume_values: %0d bad reports, want 0", badval); end
   endtask

   task automatic test_stuck_high();
      enable = 1'b0;
      hold(1'b1, 4);
      enable = 1'b1;
      clear_stats(0, 0);
      hold(1'b1, 200);
      n_tests++; if (signal_lost !== 1'b1 || pwm_level !== 1'b1) begin n_fail++; $display("FAIL high_flags: lost=%b level=%b want 1/1", signal_lost, pwm_level); end
      n_tests++; if (vld_cnt !== 0) begin n_fail++; $display("FAIL high_valid_count: got %0d want 0", vld_cnt); end
   endtask

   task automatic test_enable_drop();
      restart();
      clear_stats(10, 3);
      drive_periods(10, 3, 3);
      step(1'b1); step(1'b1); step(1'b0);
      n_tests++; if (period_cycles !== 32'd10) begin n_fail++; $display("FAIL drop_before: got %0d want 10", period_cycles); end
      enable = 1'b0;
      step(1'b0);
      n_tests++; if (period_cycles !== 32'd0 || high_cycles !== 32'd0) begin n_fail++; $display("FAIL drop_outputs: got %0d/%0d want 0/0", period_cycles, high_cycles); end
      n_tests++; if (meas_valid !== 1'b0 || signal_lost !== 1'b0) begin n_fail++; $display("FAIL drop_flags: valid=%b lost=%b want 0/0", meas_valid, signal_lost); end
      // Re-enable with the input already high: the first counted rise is the next one.
      hold(1'b1, 4);
      enable = 1'b1;
      clear_stats(10, 3);
      hold(1'b1, 2);
      hold(1'b0, 7);
      drive_periods(10, 3, 3);
      hold(1'b0, 5);
      n_tests++; if (first_vld !== 23) begin n_fail++; $display("FAIL reen_first_valid_cycle: got %0d want 23", first_vld); end
      n_tests++; if (vld_cnt !== 2) begin n_fail++; $display("FAIL reen_valid_count: got %0d want 2", vld_cnt); end
      n_tests++; if (badval !== 0) begin n_fail++; $display("FAIL reen_values: %0d bad reports, want 0", badval); end
   endtask

   task automatic test_async_reset();
      restart();
      clear_stats(10, 3);
      drive_periods(10, 3, 3);
      step(1'b1); step(1'b1); step(1'b0); step(1'b0);
      n_tests++; if (period_cycles !== 32'd10) begin n_fail++; $display("FAIL areset_before: got %0d want 10", period_cycles); end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++; if (period_cycles !== 32'd0 || high_cycles !== 32'd0) begin n_fail++; $display("FAIL areset_outputs: got %0d/%0d want 0/0", period_cycles, high_cycles); end
      n_tests++; if ({meas_valid, signal_lost, pwm_level} !== 3'b000) begin n_fail++; $display("FAIL areset_flags: got %b want 000", {meas_valid, signal_lost, pwm_level}); end
      @(negedge clk);
      pwm_in = 1'b0;
      rst_n  = 1'b1;
      clear_stats(10, 3);
      drive_periods(10, 3, 3);
      hold(1'b0, 5);
      n_tests++; if (first_vld !== 14) begin n_fail++; $display("FAIL areset_first_valid_cycle: got %0d want 14", first_vld); end
      n_tests++; if (vld_cnt !== 2 || badval !== 0) begin n_fail++; $display("FAIL areset_reports: count=%0d bad=%0d want 2/0", vld_cnt, badval); end
      n_tests++; if (period_cycles !== 32'd10 || high_cycles !== 32'd3) begin n_fail++; $display("FAIL areset_outputs_after: got %0d/%0d want 10/3", period_cycles, high_cycles); end
   endtask

   initial begin
      clear_stats(0, 0);
      test_reset();
      test_basic_p10();
      test_min_p2();
      test_timeout_low();
      test_stuck_high();
      test_enable_drop();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
